// File: rtl/decode_sb_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction field extraction and
// the instruction format classes used by the decode stage.
package decode_sb_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_S, CLS_B, CLS_U, CLS_J, CLS_ILL
  } inst_cls_e;

  function automatic logic [6:0] f_opcode(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic logic [4:0] f_rs1(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [31:0] inst);
    return inst[24:20];
  endfunction

  function automatic inst_cls_e classify(input logic [6:0] opc);
    case (opc)
      OPC_OP:                       return CLS_R;
      OPC_OPIMM, OPC_JALR, OPC_LOAD: return CLS_I;
      OPC_STORE:                    return CLS_S;
      OPC_BRANCH:                   return CLS_B;
      OPC_LUI, OPC_AUIPC:           return CLS_U;
      OPC_JAL:                      return CLS_J;
      default:                      return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/decode_sb_if.sv
// Decode stage bus: fetch-side handshake, regfile read ports, writeback
// ports, flush and the registered execute-side output.
interface decode_sb_if #(
    parameter int XLEN   = 32,
    parameter int NUM_WB = 2
);
    logic                   valid_i;
    logic                   ready_o;
    logic [31:0]            pc_i;
    logic [31:0]            inst_i;
    logic [4:0]             rs1num_o;
    logic [4:0]             rs2num_o;
    logic [XLEN-1:0]        r0data_i;
    logic [XLEN-1:0]        r1data_i;
    logic [NUM_WB-1:0]      wb_valid_i;
    logic [5*NUM_WB-1:0]    wb_rd_i;
    logic [XLEN*NUM_WB-1:0] wb_data_i;
    logic                   flush_i;
    logic                   valid_ro;
    logic                   ready_i;
    logic [31:0]            pc_ro;
    logic [31:0]            inst_ro;
    logic [4:0]             rd_ro;
    logic [XLEN-1:0]        r0data_ro;
    logic [XLEN-1:0]        r1data_ro;
    logic [XLEN-1:0]        imm_ro;
    logic                   illegal_ro;

    modport slave (
        input  valid_i, pc_i, inst_i, r0data_i, r1data_i, wb_valid_i, wb_rd_i,
               wb_data_i, flush_i, ready_i,
        output ready_o, rs1num_o, rs2num_o, valid_ro, pc_ro, inst_ro, rd_ro,
               r0data_ro, r1data_ro, imm_ro, illegal_ro
    );

    modport master (
        output valid_i, pc_i, inst_i, r0data_i, r1data_i, wb_valid_i, wb_rd_i,
               wb_data_i, flush_i, ready_i,
        input  ready_o, rs1num_o, rs2num_o, valid_ro, pc_ro, inst_ro, rd_ro,
               r0data_ro, r1data_ro, imm_ro, illegal_ro
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register, cleared
// by writebacks, set by issued instructions, looked up for RAW/WAW hazards.
module decode_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int NUM_WB   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [4:0]          rd,
    input  logic                rs1_use,
    input  logic                rs2_use,
    input  logic                rd_use,
    input  logic                set_i,
    input  logic [NUM_WB-1:0]   wb_valid,
    input  logic [5*NUM_WB-1:0] wb_rd,
    output logic                hazard_o
);

    logic [NUM_REGS-1:0] sb;
    logic [31:0]         pend;
    logic [31:0]         clr;
    logic [31:0]         set;

    // Lookups run over the full 5-bit index space; RV32E callers never flag
    // an index >= 16 as used, so the zero padding is never consulted.
    assign pend = 32'(sb);

    // NOTE: every always_comb output gets a default before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        clr = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && (wb_rd[5*k +: 5] != 5'd0)) clr[wb_rd[5*k +: 5]] = 1'b1;
        end
        set = '0;
        if (set_i && rd_use) set[rd] = 1'b1;
    end

    assign hazard_o = (rs1_use && pend[rs1] && !clr[rs1]) ||
                      (rs2_use && pend[rs2] && !clr[rs2]) ||
                      (rd_use  && pend[rd]  && !clr[rd]);

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sb <= '0;
        else      sb <= (sb & ~clr[NUM_REGS-1:0]) | set[NUM_REGS-1:0];
    end

endmodule

// File: rtl/decode_sb.sv
// RV32I decode stage with scoreboard stalls, writeback forwarding, flush and a
// single registered output slot towards execute.
module decode_sb
    import decode_sb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_WB   = 2
) (
    input logic       clk,
    input logic       rst,
    decode_sb_if.slave bus
);

    logic [31:0]     inst;
    inst_cls_e       cls;
    logic [4:0]      rs1, rs2, rd;
    logic            rs1_use, rs2_use, rd_wr, bad_reg, illegal;
    logic            hazard, cke, fire;
    logic [XLEN-1:0] imm;

    logic            valid_q, ill_q;
    logic [31:0]     pc_q, inst_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] r0_q, r1_q, imm_q;

    assign inst = bus.inst_i;
    assign cls  = classify(f_opcode(inst));
    assign rs1  = f_rs1(inst);
    assign rs2  = f_rs2(inst);
    assign rd   = f_rd(inst);

    assign bus.rs1num_o = rs1;
    assign bus.rs2num_o = rs2;

    always_comb begin
        rs1_use = cls inside {CLS_R, CLS_I, CLS_S, CLS_B};
        rs2_use = cls inside {CLS_R, CLS_S, CLS_B};
        rd_wr   = (cls inside {CLS_R, CLS_I, CLS_U, CLS_J}) && (rd != 5'd0);
        bad_reg = (NUM_REGS == 16) &&
                  ((rs1_use && rs1[4]) || (rs2_use && rs2[4]) || (rd_wr && rd[4]));
        illegal = (cls == CLS_ILL) || bad_reg;
    end

    always_comb begin
        imm = '0;
        case (cls)
            CLS_I: imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
            CLS_S: imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            CLS_B: imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            CLS_U: imm = XLEN'({inst[31:12], 12'b0});
            CLS_J: imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        if (illegal) imm = '0;
    end

    // Ascending scan, so the highest-index matching writeback port wins.
    function automatic logic [XLEN-1:0] forward(
        input logic [4:0]             src,
        input logic [XLEN-1:0]        rf,
        input logic [NUM_WB-1:0]      wbv,
        input logic [5*NUM_WB-1:0]    wbrd,
        input logic [XLEN*NUM_WB-1:0] wbd
    );
        logic [XLEN-1:0] v;
        v = rf;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wbv[k] && (wbrd[5*k +: 5] == src) && (src != 5'd0)) v = wbd[XLEN*k +: XLEN];
        end
        return v;
    endfunction

    decode_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_WB(NUM_WB)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .rs1_use  (rs1_use && !illegal),
        .rs2_use  (rs2_use && !illegal),
        .rd_use   (rd_wr && !illegal),
        .set_i    (fire),
        .wb_valid (bus.wb_valid_i),
        .wb_rd    (bus.wb_rd_i),
        .hazard_o (hazard)
    );

    assign cke         = !valid_q || bus.ready_i;
    assign bus.ready_o = bus.flush_i || (cke && !hazard);
    assign fire        = bus.valid_i && cke && !hazard && !bus.flush_i;

    // Flush only kills the valid bit; the held payload is don't-care afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            rd_q    <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            imm_q   <= '0;
            ill_q   <= 1'b0;
        end else if (bus.flush_i) begin
            valid_q <= 1'b0;
        end else if (fire) begin
            valid_q <= 1'b1;
            pc_q    <= bus.pc_i;
            inst_q  <= inst;
            rd_q    <= (rd_wr && !illegal) ? rd : 5'd0;
            r0_q    <= forward(rs1, bus.r0data_i, bus.wb_valid_i, bus.wb_rd_i, bus.wb_data_i);
            r1_q    <= forward(rs2, bus.r1data_i, bus.wb_valid_i, bus.wb_rd_i, bus.wb_data_i);
            imm_q   <= imm;
            ill_q   <= illegal;
        end else if (cke) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.valid_ro   = valid_q;
    assign bus.pc_ro      = pc_q;
    assign bus.inst_ro    = inst_q;
    assign bus.rd_ro      = rd_q;
    assign bus.r0data_ro  = r0_q;
    assign bus.r1data_ro  = r1_q;
    assign bus.imm_ro     = imm_q;
    assign bus.illegal_ro = ill_q;

endmodule

// File: tb/tb_decode_sb.sv
// Self-checking bench for decode_sb: hand sequences for stalls, forwarding,
// hold/flush and reset, a vector table, and an RV32E instance.
module tb_decode_sb;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] r0_in;
        logic [31:0] r1_in;
        logic [1:0]  wbv;
        logic [9:0]  wbrd;
        logic [63:0] wbd;
        logic [4:0]  rd;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    exp_t e;
    vec_t vecs[10];

    always #5 clk = ~clk;

    decode_sb_if #(.XLEN(32), .NUM_WB(2)) bus32();
    decode_sb_if #(.XLEN(32), .NUM_WB(2)) bus16();

    decode_sb #(.XLEN(32), .NUM_REGS(32), .NUM_WB(2)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    decode_sb #(.XLEN(32), .NUM_REGS(16), .NUM_WB(2)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] r0, input logic [31:0] r1, input logic [1:0] wbv,
                       input logic [9:0] wbrd, input logic [63:0] wbd, input logic rdy,
                       input logic fl);
        bus32.valid_i    = v;
        bus32.pc_i       = pc;
        bus32.inst_i     = inst;
        bus32.r0data_i   = r0;
        bus32.r1data_i   = r1;
        bus32.wb_valid_i = wbv;
        bus32.wb_rd_i    = wbrd;
        bus32.wb_data_i  = wbd;
        bus32.ready_i    = rdy;
        bus32.flush_i    = fl;
    endtask

    function automatic void expect_out(input logic [31:0] pc, input logic [31:0] inst,
                                       input logic [4:0] rd, input logic [31:0] r0,
                                       input logic [31:0] r1, input logic [31:0] imm,
                                       input logic ill);
        q.push_back('{pc: pc, inst: inst, rd: rd, r0: r0, r1: r1, imm: imm, ill: ill});
    endfunction

    // Output monitor: every accepted output must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && bus32.valid_ro && bus32.ready_i) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: valid_ro=1 inst_ro=%h, expected no output", bus32.inst_ro);
            end else begin
                e = q.pop_front();
                check("out_pc",      bus32.pc_ro,             e.pc);
                check("out_inst",    bus32.inst_ro,           e.inst);
                check("out_rd",      32'(bus32.rd_ro),        32'(e.rd));
                check("out_r0",      bus32.r0data_ro,         e.r0);
                check("out_r1",      bus32.r1data_ro,         e.r1);
                check("out_imm",     bus32.imm_ro,            e.imm);
                check("out_illegal", 32'(bus32.illegal_ro),   32'(e.ill));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'hFFF10093, 32'h100, 32'h11111111, 32'h22222222, 2'b00, 10'h000, 64'h0,
                    5'd1, 32'h11111111, 32'h22222222, 32'hFFFFFFFF, 1'b0};
        vecs[1] = '{32'h00322423, 32'h104, 32'h33333333, 32'h44444444, 2'b00, 10'h000, 64'h0,
                    5'd0, 32'h33333333, 32'h44444444, 32'h00000008, 1'b0};
        vecs[2] = '{32'hFF80A303, 32'h108, 32'h55555555, 32'h66666666, 2'b01, 10'h001,
                    {32'h0, 32'hCAFE0001}, 5'd6, 32'hCAFE0001, 32'h66666666, 32'hFFFFFFF8, 1'b0};
        vecs[3] = '{32'h0083C863, 32'h10C, 32'h77777777, 32'h88888888, 2'b00, 10'h000, 64'h0,
                    5'd0, 32'h77777777, 32'h88888888, 32'h00000010, 1'b0};
        vecs[4] = '{32'hFFDFF4EF, 32'h110, 32'h99999999, 32'hAAAAAAAA, 2'b00, 10'h000, 64'h0,
                    5'd9, 32'h99999999, 32'hAAAAAAAA, 32'hFFFFFFFC, 1'b0};
        vecs[5] = '{32'hFFFFF517, 32'h114, 32'h0, 32'h0, 2'b00, 10'h000, 64'h0,
                    5'd10, 32'h0, 32'h0, 32'hFFFFF000, 1'b0};
        vecs[6] = '{32'h12345FFF, 32'h118, 32'h1, 32'h2, 2'b00, 10'h000, 64'h0,
                    5'd0, 32'h1, 32'h2, 32'h0, 1'b1};
        vecs[7] = '{32'h00D605B3, 32'h11C, 32'h0, 32'h0, 2'b11, 10'h1AC,
                    {32'hBBBB0000, 32'hAAAA0000}, 5'd11, 32'hAAAA0000, 32'hBBBB0000, 32'h0, 1'b0};
        vecs[8] = '{32'h00500713, 32'h120, 32'h12121212, 32'h34343434, 2'b01, 10'h000,
                    {32'h0, 32'h0000DEAD}, 5'd14, 32'h12121212, 32'h34343434, 32'h5, 1'b0};
        vecs[9] = '{32'h00008067, 32'h124, 32'h0F0F0F0F, 32'hF0F0F0F0, 2'b00, 10'h000, 64'h0,
                    5'd0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0, 1'b0};

        drv(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 10'h0, 64'h0, 1'b1, 1'b0);
        bus16.valid_i = 1'b0;    bus16.pc_i = '0;       bus16.inst_i = '0;
        bus16.r0data_i = '0;     bus16.r1data_i = '0;   bus16.wb_valid_i = '0;
        bus16.wb_rd_i = '0;      bus16.wb_data_i = '0;  bus16.ready_i = 1'b1;
        bus16.flush_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid",   32'(bus32.valid_ro),   32'h0);
        check("rst_pc",      bus32.pc_ro,           32'h0);
        check("rst_inst",    bus32.inst_ro,         32'h0);
        check("rst_imm",     bus32.imm_ro,          32'h0);
        check("rst_illegal", 32'(bus32.illegal_ro), 32'h0);
        check("rst_sb",      dut32.u_sb.sb,         32'h0);
        check("rst_ready",   32'(bus32.ready_o),    32'h1);
        @(posedge clk); #1 rst = 1'b1;

        // RV32E instance: out-of-range register is illegal and reserves nothing
        @(posedge clk); #1;
        bus16.valid_i = 1'b1; bus16.pc_i = 32'h40; bus16.inst_i = 32'h00100A13;
        @(negedge clk);
        check("e_ready_illegal", 32'(bus16.ready_o), 32'h1);
        @(posedge clk); #1 bus16.valid_i = 1'b0;
        check("e_valid",   32'(bus16.valid_ro),   32'h1);
        check("e_illegal", 32'(bus16.illegal_ro), 32'h1);
        check("e_rd",      32'(bus16.rd_ro),      32'h0);
        check("e_imm",     bus16.imm_ro,          32'h0);
        check("e_sb",      32'(dut16.u_sb.sb),    32'h0);
        bus16.valid_i = 1'b1; bus16.inst_i = 32'h00300293;
        @(posedge clk); #1 bus16.valid_i = 1'b0;
        check("e_legal_illegal", 32'(bus16.illegal_ro), 32'h0);
        check("e_legal_imm",     bus16.imm_ro,          32'h3);
        check("e_legal_rd",      32'(bus16.rd_ro),      32'h5);
        check("e_legal_sb",      32'(dut16.u_sb.sb),    32'h20);
        bus16.valid_i = 1'b1; bus16.inst_i = 32'h000880B3;
        @(posedge clk); #1 bus16.valid_i = 1'b0;
        check("e_rs1_illegal", 32'(bus16.illegal_ro), 32'h1);
        check("e_rs1_sb",      32'(dut16.u_sb.sb),    32'h20);

        // ADDI x5,x0,3 then dependent ADD x6,x5,x5 stalls until writeback
        @(posedge clk); #1;
        drv(1'b1, 32'h200, 32'h00300293, 32'h0, 32'h0, 2'b00, 10'h0, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("addi_ready", 32'(bus32.ready_o), 32'h1);
        expect_out(32'h200, 32'h00300293, 5'd5, 32'h0, 32'h0, 32'h3, 1'b0);
        @(posedge clk); #1;
        drv(1'b1, 32'h204, 32'h00528333, 32'h99, 32'h99, 2'b00, 10'h0, 64'h0, 1'b1, 1'b0);
        check("addi_sb", dut32.u_sb.sb, 32'h20);
        @(negedge clk);
        check("raw_ready",  32'(bus32.ready_o),  32'h0);
        check("addi_valid", 32'(bus32.valid_ro), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bubble_valid", 32'(bus32.valid_ro), 32'h0);
        check("bubble_ready", 32'(bus32.ready_o),  32'h0);
        @(posedge clk); #1;
        drv(1'b1, 32'h204, 32'h00528333, 32'h99, 32'h99, 2'b01, 10'd5, {32'h0, 32'h3}, 1'b1, 1'b0);
        @(negedge clk);
        check("wb_release_ready", 32'(bus32.ready_o), 32'h1);
        expect_out(32'h204, 32'h00528333, 5'd6, 32'h3, 32'h3, 32'h0, 1'b0);

        // SW x7,0(x0) with both ports writing x7: port 1 wins
        @(posedge clk); #1;
        drv(1'b1, 32'h208, 32'h00702023, 32'h0, 32'h77, 2'b11, 10'h0E7, {32'hB, 32'hA}, 1'b1, 1'b0);
        check("add_sb", dut32.u_sb.sb, 32'h40);
        @(negedge clk);
        expect_out(32'h208, 32'h00702023, 5'd0, 32'h0, 32'hB, 32'h0, 1'b0);

        // Downstream stall: output holds while a new instruction waits
        @(posedge clk); #1;
        drv(1'b1, 32'h20C, 32'h00100413, 32'h0, 32'h0, 2'b00, 10'h0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus32.valid_ro), 32'h1);
            check("hold_ready", 32'(bus32.ready_o),  32'h0);
            check("hold_inst",  bus32.inst_ro,       32'h00702023);
            check("hold_r1",    bus32.r1data_ro,     32'hB);
            @(posedge clk); #1;
        end
        bus32.flush_i = 1'b1;
        @(negedge clk);
        check("flush_ready", 32'(bus32.ready_o), 32'h1);
        @(posedge clk); #1;
        void'(q.pop_front());
        check("flush_valid", 32'(bus32.valid_ro), 32'h0);
        check("flush_sb",    dut32.u_sb.sb,       32'h40);

        // BEQ x0,x0,-4 and LUI x1,0x12345
        drv(1'b1, 32'h300, 32'hFE000EE3, 32'h0, 32'h0, 2'b00, 10'h0, 64'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("beq_ready", 32'(bus32.ready_o), 32'h1);
        expect_out(32'h300, 32'hFE000EE3, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFC, 1'b0);
        @(posedge clk); #1;
        drv(1'b1, 32'h304, 32'h123450B7, 32'h0, 32'h0, 2'b00, 10'h0, 64'h0, 1'b1, 1'b0);
        check("beq_sb", dut32.u_sb.sb, 32'h40);
        @(negedge clk);
        expect_out(32'h304, 32'h123450B7, 5'd1, 32'h0, 32'h0, 32'h12345000, 1'b0);

        // ADD x2,x1,x1 stalls behind LUI; reset mid-stall clears everything
        @(posedge clk); #1;
        drv(1'b1, 32'h308, 32'h00108133, 32'h0, 32'h0, 2'b00, 10'h0, 64'h0, 1'b0, 1'b0);
        check("lui_sb",    dut32.u_sb.sb,       32'h42);
        check("lui_valid", 32'(bus32.valid_ro), 32'h1);
        @(negedge clk);
        check("stall_ready", 32'(bus32.ready_o), 32'h0);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 32'(bus32.valid_ro), 32'h0);
        check("arst_sb",    dut32.u_sb.sb,       32'h0);
        check("arst_imm",   bus32.imm_ro,        32'h0);
        check("arst_pc",    bus32.pc_ro,         32'h0);
        q.delete();
        @(posedge clk); #1;
        drv(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 10'h0, 64'h0, 1'b1, 1'b0);
        rst = 1'b1;

        // Back-to-back vector table
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drv(1'b1, vecs[i].pc, vecs[i].inst, vecs[i].r0_in, vecs[i].r1_in,
                vecs[i].wbv, vecs[i].wbrd, vecs[i].wbd, 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 32'(bus32.ready_o), 32'h1);
            expect_out(vecs[i].pc, vecs[i].inst, vecs[i].rd, vecs[i].r0, vecs[i].r1,
                       vecs[i].imm, vecs[i].ill);
        end
        @(posedge clk); #1;
        drv(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 10'h0, 64'h0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("drain_queue", 32'(q.size()),   32'h0);
        check("table_sb",    dut32.u_sb.sb,   32'h00004E40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
